// File: rtl/req_hold.sv
// req_hold: per-port request holding stage in front of the priority selector.
// Each port accepts one request, holds its payload until the selector grants
// and completes it, then returns the selector's response to the client.
// It also tracks how long each request has waited and flags starving ports.
module req_hold #(
  parameter int  NumPorts    = 4,
  parameter type T           = logic [7:0],
  parameter type O           = logic [7:0],
  parameter int  StarveLimit = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NumPorts-1:0] req_valid,
  input  T [NumPorts-1:0]     req_data,
  output logic [NumPorts-1:0] req_ready,
  output logic [NumPorts-1:0] rsp_valid,
  output O [NumPorts-1:0]     rsp_data,
  input  logic [NumPorts-1:0] rsp_ready,
  output logic [NumPorts-1:0] pend,
  output T [NumPorts-1:0]     held,
  input  logic [NumPorts-1:0] grant,
  input  logic                sel_done,
  input  O [NumPorts-1:0]     sel_rsp,
  output logic [NumPorts-1:0] starve,
  output logic                err
);

  localparam int AW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
  localparam logic [AW-1:0] AgeMax = AW'(StarveLimit);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RESP
  } state_t;

  state_t          state_q [NumPorts];
  state_t          state_d [NumPorts];
  logic [AW-1:0]   age_q   [NumPorts];
  logic            err_d;

  // Per-port state, payload, response and age registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        state_q[i]  <= IDLE;
        age_q[i]    <= '0;
        held[i]     <= '0;
        rsp_data[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        state_q[i] <= state_d[i];
        case (state_q[i])
          IDLE: begin
            if (req_valid[i]) begin
              held[i]  <= req_data[i];
              age_q[i] <= '0;
            end
          end
          PEND: begin
            if (sel_done && grant[i]) begin
              rsp_data[i] <= sel_rsp[i];
              age_q[i]    <= '0;
            end else if (age_q[i] != AgeMax) begin
              age_q[i] <= age_q[i] + AW'(1);
            end
          end
          default: ;
        endcase
      end
      err <= err_d;
    end
  end

  // Next-state per port plus protocol-error detection on sel_done.
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (req_valid[i])           state_d[i] = PEND;
        PEND:    if (sel_done && grant[i])   state_d[i] = RESP;
        RESP:    if (rsp_ready[i])           state_d[i] = IDLE;
        default:                             state_d[i] = IDLE;
      endcase
    end
    err_d = sel_done &&
            ((grant == '0) || ($countones(grant) > 1) || ((grant & ~pend) != '0));
  end

  // Handshake and status outputs decoded from registered state only.
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      req_ready[i] = (state_q[i] == IDLE);
      pend[i]      = (state_q[i] == PEND);
      rsp_valid[i] = (state_q[i] == RESP);
      starve[i]    = (state_q[i] == PEND) && (age_q[i] == AgeMax);
    end
  end

endmodule

// File: tb/tb_req_hold.sv
// tb_req_hold: directed test-plan steps followed by randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_req_hold;

  localparam int N     = 4;
  localparam int LIMIT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0]     pend, grant, starve;
  logic [N-1:0][7:0] req_data, rsp_data, held, sel_rsp;
  logic             sel_done, err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: per-port "has request" / "has response" flags.
  bit        m_pend [N];
  bit        m_rsp  [N];
  int        m_wait [N];
  logic [7:0] m_held [N];
  logic [7:0] m_rdat [N];
  bit        m_err;

  always #5 clk = ~clk;

  req_hold #(
    .NumPorts   (N),
    .T          (logic [7:0]),
    .O          (logic [7:0]),
    .StarveLimit(LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready),
    .pend     (pend),
    .held     (held),
    .grant    (grant),
    .sel_done (sel_done),
    .sel_rsp  (sel_rsp),
    .starve   (starve),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit nonpend_grant;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_rsp[i] = 0; m_wait[i] = 0;
        m_held[i] = '0; m_rdat[i] = '0;
      end
      m_err = 0;
      return;
    end
    nonpend_grant = 0;
    for (int i = 0; i < N; i++)
      if (grant[i] && !m_pend[i]) nonpend_grant = 1;
    m_err = sel_done && (grant == 0 || $countones(grant) > 1 || nonpend_grant);
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) begin
        if (sel_done && grant[i]) begin
          m_pend[i] = 0; m_rsp[i] = 1; m_rdat[i] = sel_rsp[i]; m_wait[i] = 0;
        end else if (m_wait[i] < LIMIT) begin
          m_wait[i]++;
        end
      end else if (m_rsp[i]) begin
        if (rsp_ready[i]) m_rsp[i] = 0;
      end else if (req_valid[i]) begin
        m_pend[i] = 1; m_held[i] = req_data[i]; m_wait[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_ready, e_pend, e_rv, e_st;
    logic [N-1:0][7:0] e_held, e_rd;
    for (int i = 0; i < N; i++) begin
      e_ready[i] = !m_pend[i] && !m_rsp[i];
      e_pend[i]  = m_pend[i];
      e_rv[i]    = m_rsp[i];
      e_st[i]    = m_pend[i] && (m_wait[i] >= LIMIT);
      e_held[i]  = m_held[i];
      e_rd[i]    = m_rdat[i];
    end
    chk("req_ready", req_ready, e_ready);
    chk("pend",      pend,      e_pend);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("starve",    starve,    e_st);
    chk("held",      held,      e_held);
    chk("rsp_data",  rsp_data,  e_rd);
    chk("err",       err,       m_err);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic clr();
    req_valid = '0; rsp_ready = '0; grant = '0; sel_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_rsp[i] = 0; m_wait[i] = 0; m_held[i] = '0; m_rdat[i] = '0;
    end
    m_err = 0;
    rst = 1'b0; clr(); req_data = '0; sel_rsp = '0;

    // Reset
    cycle(); cycle();
    rst = 1'b1;
    chk("rst_ready", req_ready, 4'b1111);
    chk("rst_pend", pend, 4'b0000);
    chk("rst_err", err, 1'b0);

    // Single round trip on port 2
    req_valid = 4'b0100; req_data[2] = 8'hA5;
    cycle(); clr();
    chk("p2_pend", pend, 4'b0100);
    chk("p2_held", held[2], 8'hA5);
    grant = 4'b0100; sel_done = 1'b1; sel_rsp[2] = 8'h3C;
    cycle(); clr();
    chk("p2_rv", rsp_valid, 4'b0100);
    chk("p2_rd", rsp_data[2], 8'h3C);
    rsp_ready = 4'b0100;
    cycle(); clr();
    chk("p2_ready", req_ready, 4'b1111);

    // Concurrent ports 0 and 3, port 0 backpressured
    req_valid = 4'b1001; req_data[0] = 8'h11; req_data[3] = 8'h33;
    cycle(); clr();
    chk("cc_pend", pend, 4'b1001);
    grant = 4'b0001; sel_done = 1'b1; sel_rsp[0] = 8'h44;
    cycle(); clr();
    chk("cc_pend0", pend, 4'b1000);
    cycle();
    grant = 4'b1000; sel_done = 1'b1; sel_rsp[3] = 8'h55;
    cycle(); clr();
    chk("cc_pend3", pend, 4'b0000);
    chk("cc_rv", rsp_valid, 4'b1001);
    rsp_ready = 4'b1000;
    cycle(); cycle(); clr();
    chk("cc_bp", rsp_valid, 4'b0001);
    chk("cc_rd0", rsp_data[0], 8'h44);
    rsp_ready = 4'b0001;
    cycle(); clr();
    chk("cc_done", rsp_valid, 4'b0000);

    // Starvation on port 1
    req_valid = 4'b0010; req_data[1] = 8'h5A;
    cycle(); clr();
    for (int k = 1; k <= LIMIT + 3; k++) begin
      cycle();
      chk("starve_t", starve, (k >= LIMIT) ? 4'b0010 : 4'b0000);
    end
    grant = 4'b0010; sel_done = 1'b1; sel_rsp[1] = 8'hC3;
    cycle(); clr();
    chk("starve_clr", starve, 4'b0000);
    rsp_ready = 4'b0010;
    cycle(); clr();

    // Protocol errors
    grant = 4'b0010; sel_done = 1'b1;
    cycle(); clr();
    chk("e_idle", err, 1'b1);
    chk("e_idle_st", req_ready, 4'b1111);
    cycle();
    chk("e_idle_off", err, 1'b0);
    req_valid = 4'b0110;
    cycle(); clr();
    grant = 4'b0110; sel_done = 1'b1; sel_rsp[1] = 8'h21; sel_rsp[2] = 8'h22;
    cycle(); clr();
    chk("e_multi", err, 1'b1);
    chk("e_multi_rv", rsp_valid, 4'b0110);
    rsp_ready = 4'b0110;
    cycle(); clr();
    chk("e_multi_off", err, 1'b0);
    sel_done = 1'b1;
    cycle(); clr();
    chk("e_zero", err, 1'b1);
    cycle();
    chk("e_zero_off", err, 1'b0);

    // Reset mid-operation
    req_valid = 4'b0101; req_data[0] = 8'h66; req_data[2] = 8'h67;
    cycle(); clr();
    grant = 4'b0100; sel_done = 1'b1; sel_rsp[2] = 8'h99;
    cycle(); clr();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("mr_ready", req_ready, 4'b1111);
    chk("mr_held", held, 32'h0);
    chk("mr_rd", rsp_data, 32'h0);
    req_valid = 4'b0001; req_data[0] = 8'h77;
    cycle(); clr();
    grant = 4'b0001; sel_done = 1'b1; sel_rsp[0] = 8'h88;
    cycle(); clr();
    chk("mr_rd0", rsp_data[0], 8'h88);
    rsp_ready = 4'b0001;
    cycle(); clr();
    chk("mr_again", req_ready, 4'b1111);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int pick;
      rst       = ($urandom_range(0, 299) != 0);
      req_valid = N'($urandom);
      req_data  = $urandom;
      sel_rsp   = $urandom;
      rsp_ready = N'($urandom);
      sel_done  = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) < 8 && m_pend[pick]) grant = N'(1) << pick;
      else grant = N'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
